// File: rtl/pio_button_in_pkg.sv
// Shared definitions for the button input PIO.
// Holds the Avalon register word offsets used by the decode and read mux.
package pio_button_in_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

endpackage

// File: rtl/pio_debounce_bit.sv
// One button bit: 2-flop synchronizer, stability counter and debounced level.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   pin_i        : raw asynchronous pin (active-low button)
//   stable_o     : debounced level
//   fall_o       : high during the cycle whose closing edge moves stable 1->0
module pio_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin_i,
  output logic stable_o,
  output logic fall_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             differ, expire;

  assign differ = (s2_q != stable_q);
  assign expire = differ && (cnt_q == CNT_MAX);

  // Any cycle where the synchronized pin matches the accepted level
  // restarts the count, so a glitch never accumulates toward acceptance.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (differ) begin
      if (expire) stable_d = s2_q;
      else        cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q     <= 1'b1;
      s2_q     <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      s1_q     <= pin_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  // Combinational so the top can set edgecapture on the same edge.
  assign fall_o   = expire & stable_q;

endmodule

// File: rtl/pio_button_in.sv
// Avalon-MM input PIO for active-low player buttons with debounce,
// sticky falling-edge capture and a maskable level interrupt.
// Ports:
//   clk, reset_n          : clock, async active-low reset
//   address, chipselect   : word offset, slave select
//   write_n, writedata    : active-low write strobe, write data
//   in_port[WIDTH]        : raw buttons (0 = pressed)
//   readdata[32]          : combinational read mux, zero wait states
//   irq                   : |(edgecapture & irqmask)
module pio_button_in
  import pio_button_in_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [WIDTH-1:0] stable, fall;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] clr_mask;
  logic             wr_en;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .pin_i   (in_port[i]),
      .stable_o(stable[i]),
      .fall_o  (fall[i])
    );
  end

  assign wr_en        = chipselect & ~write_n;
  // Bits above WIDTH are deliberately dropped.
  assign unused_wdata = ^writedata;

  always_comb begin
    irqmask_d = irqmask_q;
    clr_mask  = '0;
    if (wr_en && address == ADDR_IRQMASK) irqmask_d = writedata[WIDTH-1:0];
    if (wr_en && address == ADDR_EDGECAP) clr_mask  = writedata[WIDTH-1:0];
    // OR-ing the new fall after the clear makes a same-edge press win.
    edgecap_d = (edgecap_q & ~clr_mask) | fall;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask_q <= '0;
      edgecap_q <= '0;
    end else begin
      irqmask_q <= irqmask_d;
      edgecap_q <= edgecap_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata[WIDTH-1:0] = stable;
      ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask_q;
      ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap_q;
      default:      readdata            = '0;
    endcase
  end

  assign irq = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_pio_button_in.sv
module tb_pio_button_in;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  pio_button_in #(.WIDTH(4), .DEBOUNCE_CYCLES(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic rd_chk(input string nm, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    chk(nm, readdata, exp);
  endtask

  task automatic irq_chk(input string nm, input logic exp);
    chk(nm, {31'b0, irq}, {31'b0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // wr, addr, wdata, expected read of same addr, expected irq
    vecs[0] = '{1'b0, 2'd0, 32'h0,        32'h0000000F, 1'b0};
    vecs[1] = '{1'b0, 2'd1, 32'h0,        32'h00000000, 1'b0};
    vecs[2] = '{1'b0, 2'd2, 32'h0,        32'h00000000, 1'b0};
    vecs[3] = '{1'b0, 2'd3, 32'h0,        32'h00000000, 1'b0};
    vecs[4] = '{1'b1, 2'd0, 32'h00000000, 32'h0000000F, 1'b0};
    vecs[5] = '{1'b1, 2'd1, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[6] = '{1'b1, 2'd2, 32'hFFFFFFF5, 32'h00000005, 1'b0};
    vecs[7] = '{1'b1, 2'd2, 32'h00000000, 32'h00000000, 1'b0};

    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 4'hF;
    tick(3);
    reset_n = 1'b1;
    tick(1);

    // reset state and basic register access
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].wr) bus_wr(vecs[i].addr, vecs[i].wdata);
      rd_chk($sformatf("vec%0d_rd", i), vecs[i].addr, vecs[i].exp_rd);
      irq_chk($sformatf("vec%0d_irq", i), vecs[i].exp_irq);
    end

    // press bit1: accepted on exactly the 18th edge
    in_port = 4'hD;
    tick(17);
    rd_chk("press1_edge17_data", 2'd0, 32'hF);
    tick(1);
    rd_chk("press1_edge18_data", 2'd0, 32'hD);
    rd_chk("press1_edgecap", 2'd3, 32'h2);
    irq_chk("press1_irq_masked", 1'b0);

    // unmask -> irq; clear -> irq drops
    bus_wr(2'd2, 32'h2);
    irq_chk("unmask_irq", 1'b1);
    bus_wr(2'd3, 32'h2);
    rd_chk("clear_edgecap", 2'd3, 32'h0);
    irq_chk("clear_irq", 1'b0);

    // release bit1: rising transition not captured
    in_port = 4'hF;
    tick(20);
    rd_chk("release1_data", 2'd0, 32'hF);
    rd_chk("release1_edgecap", 2'd3, 32'h0);

    // short glitch on bit0 never accepted
    in_port = 4'hE;
    for (int c = 0; c < 10; c++) begin
      tick(1);
      rd_chk("glitch10_data", 2'd0, 32'hF);
    end
    in_port = 4'hF;
    tick(20);
    rd_chk("glitch10_data_end", 2'd0, 32'hF);

    // one-cycle high blip restarts the count
    in_port = 4'hE; tick(12);
    in_port = 4'hF; tick(1);
    in_port = 4'hE; tick(12);
    in_port = 4'hF;
    tick(20);
    rd_chk("glitch_restart_data", 2'd0, 32'hF);
    rd_chk("glitch_edgecap", 2'd3, 32'h0);

    // bit2 fall on the same edge as a clear of bit2: set wins
    in_port = 4'hB;
    tick(17);
    bus_wr(2'd3, 32'h4);
    rd_chk("setwins_edgecap", 2'd3, 32'h4);
    rd_chk("setwins_data", 2'd0, 32'hB);
    irq_chk("setwins_irq_masked", 1'b0);
    bus_wr(2'd3, 32'hFFFFFFFF);
    rd_chk("clear_all_edgecap", 2'd3, 32'h0);
    in_port = 4'hF;
    tick(20);
    rd_chk("release2_data", 2'd0, 32'hF);

    // reset during bit3 debounce, pin held low across release
    in_port = 4'h7;
    tick(10);
    reset_n = 1'b0;
    #1;
    rd_chk("midrst_data", 2'd0, 32'hF);
    rd_chk("midrst_irqmask", 2'd2, 32'h0);
    tick(2);
    reset_n = 1'b1;
    tick(17);
    rd_chk("postrst_edge17_data", 2'd0, 32'hF);
    rd_chk("postrst_edge17_edgecap", 2'd3, 32'h0);
    tick(1);
    rd_chk("postrst_edge18_data", 2'd0, 32'h7);
    rd_chk("postrst_edgecap", 2'd3, 32'h8);
    tick(20);
    rd_chk("postrst_single_capture", 2'd3, 32'h8);
    bus_wr(2'd2, 32'h8);
    irq_chk("postrst_irq", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
